uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single UART transmitter among N_REQ on-chip requesters. It accepts one byte plus frame configuration from the winning requester and drives the UART write strobe and transmit inputs. It then waits for the transmitter's end-of-frame interrupt and reports completion or timeout back with the requester index. It sits between the CPU-side producers and the UART block, on the clk_CPU domain.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rr_arbiter.sv | 48 ++++
 rtl/uart_tx_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit scheduler, its round-robin
// arbiter and the UART block itself.
//   - state encoding for the scheduler FSM (IDLE/WRITE/WAIT/DONE)
//   - UART_PARITY codes understood by the transmitter
//   - done_kind encoding reported at the end of a frame
package uart_pkg;

  localparam logic [1:0] ST_ENC_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENC_WRITE = 2'd1;
  localparam logic [1:0] ST_ENC_WAIT  = 2'd2;
  localparam logic [1:0] ST_ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_ENC_IDLE,
    ST_WRITE = ST_ENC_WRITE,
    ST_WAIT  = ST_ENC_WAIT,
    ST_DONE  = ST_ENC_DONE
  } state_t;

  // Parity codes driven on UART_PARITY; 2'b11 is reserved by the UART block.
  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  typedef enum logic {
    DONE_OK      = 1'b0,
    DONE_TIMEOUT = 1'b1
  } done_kind_t;

  // True when the code is one the transmitter implements.
  function automatic logic parity_known(input logic [1:0] p);
    logic ok;
    case (p)
      PARITY_NONE: ok = 1'b1;
      PARITY_ODD:  ok = 1'b1;
      PARITY_EVEN: ok = 1'b1;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin picker.
// The search starts at i_last_grant+1 and wraps modulo N_REQ; the first valid
// requester found is the winner. Reusable by an Rx-side dispatcher.
// Ports:
//   i_req_valid   [N_REQ-1:0]  request vector
//   i_last_grant  [IDW-1:0]    index granted last time
//   o_winner      [IDW-1:0]    selected index (0 when nothing is valid)
//   o_any_valid                at least one request is valid
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [IDW-1:0]   i_last_grant,
  output logic [IDW-1:0]   o_winner,
  output logic             o_any_valid
);

  int             w_idx;
  logic [IDW-1:0] w_sel;

  // Walk from the farthest offset down to the nearest so that the requester
  // closest after last_grant is the one left in o_winner.
  always_comb begin
    o_winner = '0;
    w_idx    = 0;
    w_sel    = '0;
    for (int off = N_REQ; off > 0; off--) begin
      w_idx = int'(i_last_grant) + off;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end else begin
        w_idx = w_idx;
      end
      w_sel = IDW'(w_idx);
      if (i_req_valid[w_sel]) begin
        o_winner = w_sel;
      end else begin
        o_winner = o_winner;
      end
    end
  end

  assign o_any_valid = |i_req_valid;

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among N_REQ requesters.
// A round-robin winner's byte and frame settings are latched, UART_WRITE is
// held for WRITE_HOLD cycles, then the end-of-frame IRQ_Tx is awaited for at
// most TIMEOUT cycles; completion or timeout is pulsed back with grant_id.
// Ports:
//   clk_CPU, RST (sync, active-high), EN (gates new grants only)
//   req_valid/req_data/req_bits/req_parity : per-requester request bundle
//   req_ready   : one-hot accept pulse
//   UART_WRITE, DATA_IN_Tx, UART_BITS, UART_PARITY : to UART; IRQ_Tx from UART
//   busy, grant_id, tx_done, tx_timeout : status
// All outputs are registered.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WRITE_HOLD = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                       clk_CPU,
  input  logic                       RST,
  input  logic                       EN,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_bits,
  input  logic [2*N_REQ-1:0]         req_parity,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       UART_WRITE,
  output logic [7:0]                 DATA_IN_Tx,
  output logic                       UART_BITS,
  output logic [1:0]                 UART_PARITY,
  input  logic                       IRQ_Tx,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       tx_done,
  output logic                       tx_timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HCW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
  localparam int WCW = $clog2(TIMEOUT);

  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(WRITE_HOLD - 1);
  localparam logic [HCW-1:0]   HOLD_ONE  = HCW'(1);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0]   WAIT_ONE  = WCW'(1);
  localparam logic [IDW-1:0]   LAST_RST  = IDW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] REQ_ONE   = N_REQ'(1);

  state_t         r_state;
  state_t         w_state_nxt;
  done_kind_t     w_kind_nxt;

  logic [HCW-1:0] r_hold_cnt;
  logic [WCW-1:0] r_wait_cnt;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] w_winner;
  logic           w_any_valid;
  logic           w_grant;

  logic [N_REQ-1:0] r_req_ready;
  logic             r_uart_write;
  logic [7:0]       r_data;
  logic             r_bits;
  logic [1:0]       r_parity;
  logic             r_busy;
  logic [IDW-1:0]   r_grant_id;
  logic             r_tx_done;
  logic             r_tx_timeout;

  logic [7:0]       w_win_data;
  logic             w_win_bits;
  logic [1:0]       w_win_parity;

  uart_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_valid  (w_any_valid)
  );

  assign w_grant      = (r_state == ST_IDLE) && EN && w_any_valid;
  assign w_win_data   = req_data[{w_winner, 3'b000} +: 8];
  assign w_win_bits   = req_bits[w_winner];
  assign w_win_parity = req_parity[{w_winner, 1'b0} +: 2];

  // FSM state register.
  always_ff @(posedge clk_CPU) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; IRQ_Tx takes priority over the terminal wait count.
  always_comb begin
    w_state_nxt = r_state;
    w_kind_nxt  = DONE_OK;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WAIT: begin
        if (IRQ_Tx) begin
          w_state_nxt = ST_DONE;
          w_kind_nxt  = DONE_OK;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = ST_DONE;
          w_kind_nxt  = DONE_TIMEOUT;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters, grant capture and output registers (driven from next state so
  // that the outputs line up with the state they describe).
  always_ff @(posedge clk_CPU) begin
    if (RST) begin
      r_hold_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_last_grant <= LAST_RST;
      r_req_ready  <= '0;
      r_uart_write <= 1'b0;
      r_data       <= 8'h00;
      r_bits       <= 1'b0;
      r_parity     <= PARITY_NONE;
      r_busy       <= 1'b0;
      r_grant_id   <= '0;
      r_tx_done    <= 1'b0;
      r_tx_timeout <= 1'b0;
    end else begin
      if (w_grant) begin
        r_data       <= w_win_data;
        r_bits       <= w_win_bits;
        r_parity     <= w_win_parity;
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
        r_req_ready  <= REQ_ONE << w_winner;
      end else begin
        r_req_ready  <= '0;
      end

      if ((r_state == ST_WRITE) && (w_state_nxt == ST_WRITE)) begin
        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
      end else begin
        r_hold_cnt <= '0;
      end

      if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
      end else begin
        r_wait_cnt <= '0;
      end

      r_uart_write <= (w_state_nxt == ST_WRITE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_tx_done    <= (w_state_nxt == ST_DONE) && (w_kind_nxt == DONE_OK);
      r_tx_timeout <= (w_state_nxt == ST_DONE) && (w_kind_nxt == DONE_TIMEOUT);
    end
  end

  assign req_ready   = r_req_ready;
  assign UART_WRITE  = r_uart_write;
  assign DATA_IN_Tx  = r_data;
  assign UART_BITS   = r_bits;
  assign UART_PARITY = r_parity;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign tx_done     = r_tx_done;
  assign tx_timeout  = r_tx_timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: transaction-level reference model (round-robin
// pick by modular search, frame timing by arithmetic) driving randomized
// requests, IRQ delays, timeouts, EN drops and a reset in the middle of WRITE.
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int H  = 16;
  localparam int T  = 50;

  logic              clk_CPU = 1'b0;
  logic              RST;
  logic              EN;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_bits;
  logic [2*NR-1:0]   req_parity;
  logic [NR-1:0]     req_ready;
  logic              UART_WRITE;
  logic [7:0]        DATA_IN_Tx;
  logic              UART_BITS;
  logic [1:0]        UART_PARITY;
  logic              IRQ_Tx;
  logic              busy;
  logic [1:0]        grant_id;
  logic              tx_done;
  logic              tx_timeout;

  uart_tx_scheduler #(
    .N_REQ      (NR),
    .WRITE_HOLD (H),
    .TIMEOUT    (T)
  ) dut (
    .clk_CPU     (clk_CPU),
    .RST         (RST),
    .EN          (EN),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_bits    (req_bits),
    .req_parity  (req_parity),
    .req_ready   (req_ready),
    .UART_WRITE  (UART_WRITE),
    .DATA_IN_Tx  (DATA_IN_Tx),
    .UART_BITS   (UART_BITS),
    .UART_PARITY (UART_PARITY),
    .IRQ_Tx      (IRQ_Tx),
    .busy        (busy),
    .grant_id    (grant_id),
    .tx_done     (tx_done),
    .tx_timeout  (tx_timeout)
  );

  always #5 clk_CPU = ~clk_CPU;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  int            last_grant;
  logic [NR-1:0] pend;
  logic [7:0]    bdata [NR];
  logic          bbits [NR];
  logic [1:0]    bpar  [NR];

  task automatic check_val(input string tag, input int got, input int exp_v);
    n_total++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NR-1:0] m);
    int c;
    for (int s = 1; s <= NR; s++) begin
      c = (last + s) % NR;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_data[8*i +: 8]   = bdata[i];
      req_bits[i]          = bbits[i];
      req_parity[2*i +: 2] = bpar[i];
    end
    req_valid = pend;
  endtask

  task automatic new_req(input int i);
    if (!pend[i]) begin
      bdata[i] = 8'($urandom);
      bbits[i] = 1'($urandom);
      bpar[i]  = 2'($urandom_range(0, 2));
      pend[i]  = 1'b1;
    end
  endtask

  // One frame, starting at a negedge with the DUT in IDLE. d_irq >= T means
  // IRQ_Tx never comes and a timeout is expected.
  task automatic run_txn(input int d_irq, input bit irq_in_write, input bit en_drop);
    int  w;
    int  hi;
    int  waited;
    int  exp_off;
    bit  seen;
    bit  extra_ready;
    if (pend == '0) new_req($urandom_range(0, NR-1));
    EN = 1'b1;
    drive_reqs();
    w = rr_pick(last_grant, pend);
    @(posedge clk_CPU);
    @(negedge clk_CPU);
    check_val("grant_ready", int'(req_ready), 1 << w);
    check_val("grant_busy", int'(busy), 1);
    check_val("grant_write", int'(UART_WRITE), 1);
    check_val("grant_data", int'(DATA_IN_Tx), int'(bdata[w]));
    check_val("grant_bits", int'(UART_BITS), int'(bbits[w]));
    check_val("grant_parity", int'(UART_PARITY), int'(bpar[w]));
    check_val("grant_id", int'(grant_id), w);
    last_grant = w;
    pend[w] = 1'b0;
    drive_reqs();
    hi = 1;
    extra_ready = 1'b0;
    while (UART_WRITE && hi < H + 5) begin
      IRQ_Tx = irq_in_write && (hi == 3);
      @(negedge clk_CPU);
      if (req_ready != '0) extra_ready = 1'b1;
      if (UART_WRITE) hi++;
    end
    IRQ_Tx = 1'b0;
    check_val("write_len", hi, H);
    check_val("ready_one_cycle", int'(extra_ready), 0);
    if (en_drop) EN = 1'b0;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < T + 5) begin
      IRQ_Tx = (d_irq < T) && (waited == d_irq);
      @(negedge clk_CPU);
      waited++;
      if (tx_done || tx_timeout) seen = 1'b1;
    end
    IRQ_Tx = 1'b0;
    exp_off = (d_irq < T) ? d_irq + 1 : T;
    check_val("done_seen", int'(seen), 1);
    check_val("done_latency", waited, exp_off);
    check_val("tx_done", int'(tx_done), (d_irq < T) ? 1 : 0);
    check_val("tx_timeout", int'(tx_timeout), (d_irq < T) ? 0 : 1);
    check_val("done_grant_id", int'(grant_id), w);
    check_val("done_data_held", int'(DATA_IN_Tx), int'(bdata[w]));
    @(negedge clk_CPU);
    check_val("idle_busy", int'(busy), 0);
    check_val("idle_pulse", int'(tx_done | tx_timeout), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad_idle;
    RST = 1'b1; EN = 1'b0; IRQ_Tx = 1'b0;
    pend = '0;
    last_grant = NR - 1;
    for (int i = 0; i < NR; i++) begin
      bdata[i] = 8'h00; bbits[i] = 1'b0; bpar[i] = 2'b00;
    end
    drive_reqs();
    repeat (3) @(negedge clk_CPU);
    check_val("rst_write", int'(UART_WRITE), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ready", int'(req_ready), 0);
    check_val("rst_data", int'(DATA_IN_Tx), 0);
    check_val("rst_bits", int'(UART_BITS), 0);
    check_val("rst_parity", int'(UART_PARITY), 0);
    check_val("rst_gid", int'(grant_id), 0);
    check_val("rst_flags", int'(tx_done | tx_timeout), 0);
    RST = 1'b0;

    // Single request from requester 0
    bdata[0] = 8'h5A; bbits[0] = 1'b1; bpar[0] = 2'b01; pend = 4'b0001;
    run_txn(30, 1'b0, 1'b0);

    // Reset in the 5th WRITE cycle
    new_req(2);
    EN = 1'b1;
    drive_reqs();
    @(posedge clk_CPU);
    @(negedge clk_CPU);
    check_val("mid_rst_pre_write", int'(UART_WRITE), 1);
    pend[2] = 1'b0;
    drive_reqs();
    repeat (4) @(negedge clk_CPU);
    RST = 1'b1;
    @(posedge clk_CPU);
    @(negedge clk_CPU);
    check_val("mid_rst_write", int'(UART_WRITE), 0);
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_ready", int'(req_ready), 0);
    check_val("mid_rst_data", int'(DATA_IN_Tx), 0);
    check_val("mid_rst_cfg", int'({UART_BITS, UART_PARITY}), 0);
    check_val("mid_rst_gid", int'(grant_id), 0);
    RST = 1'b0;
    last_grant = NR - 1;

    // Fairness: all four held, each re-raised right after its frame
    for (int i = 0; i < NR; i++) new_req(i);
    for (int n = 0; n < 6; n++) begin
      run_txn($urandom_range(0, T - 2), 1'b1, 1'b0);
      new_req(last_grant);
    end

    // Timeout, then the next requester is granted
    run_txn(T + 7, 1'b0, 1'b0);
    // IRQ_Tx on the terminal wait cycle wins over timeout
    run_txn(T - 1, 1'b0, 1'b0);

    // EN dropped in WAIT: frame finishes, no new grant until EN returns
    for (int i = 0; i < NR; i++) new_req(i);
    run_txn(10, 1'b0, 1'b1);
    bad_idle = 1'b0;
    repeat (8) begin
      @(negedge clk_CPU);
      if (req_ready != '0 || busy) bad_idle = 1'b1;
    end
    check_val("en_off_no_grant", int'(bad_idle), 0);
    run_txn(5, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 15; n++) begin
      int d;
      int j;
      if ($urandom_range(0, 1) == 1) new_req($urandom_range(0, NR-1));
      if ($urandom_range(0, 3) == 0 && $countones(pend) > 1) begin
        j = $urandom_range(0, NR-1);
        pend[j] = 1'b0;
      end
      d = ($urandom_range(0, 4) == 0) ? T + $urandom_range(0, 5) : $urandom_range(0, T-1);
      run_txn(d, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
